// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ALU, serial shifter and link/upper-immediate results.
// Define RV32M_DIV_EN to add the iterative restoring divider (DIV/DIVU/REM/REMU).
module ex_stage #(
  parameter int SHIFT_SERIAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm_data,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func3,
  input  logic [3:0]  i_alu_ctrl,
  input  logic [31:0] i_pc,
  input  logic        i_ce,
  input  logic        i_div,
  input  logic        i_stall,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic [31:0] o_rs2_data,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_func3,
  output logic [31:0] o_pc,
  output logic        o_ce
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef RV32M_DIV_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t      state, next_state;
  logic [31:0] op_a, op_b, alu_res, single_res, work, shift_step;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;
  logic [5:0]  count;
  logic        accept, overrides, is_shift, serial_go, last_step;
  logic        sh_left, sh_arith;

  assign op_a      = (i_opcode == OP_AUIPC) ? i_pc : i_rs1_data;
  assign op_b      = (i_opcode == OP_R) ? i_rs2_data : i_imm_data;
  assign shamt     = op_b[4:0];
  assign accept    = i_ce && (state == IDLE) && !i_stall;
  assign last_step = (count == 6'd1);
  assign o_stall   = i_stall || (state != IDLE);

  // Memory and branch ops always need rs1+imm, whatever func3 ID folded into alu_ctrl.
  assign alu_op    = (i_opcode == OP_LOAD || i_opcode == OP_STORE || i_opcode == OP_BRANCH)
                     ? 4'b0000 : i_alu_ctrl;
  assign overrides = (i_opcode == OP_LUI) || (i_opcode == OP_JAL) || (i_opcode == OP_JALR);
  assign is_shift  = !overrides && (alu_op == 4'b0001 || alu_op == 4'b0101 || alu_op == 4'b1101);
  assign serial_go = (SHIFT_SERIAL != 0) && is_shift && (shamt != 5'd0);

  assign shift_step = sh_left ? {work[30:0], 1'b0} : {sh_arith & work[31], work[31:1]};

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      4'b0000: alu_res = op_a + op_b;
      4'b1000: alu_res = op_a - op_b;
      4'b0001: alu_res = op_a << shamt;
      4'b0010: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'b0011: alu_res = {31'd0, op_a < op_b};
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = op_a >> shamt;
      4'b1101: alu_res = $unsigned($signed(op_a) >>> shamt);
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      default: alu_res = 32'd0;
    endcase
    if (i_opcode == OP_LUI)
      single_res = i_imm_data;
    else if (i_opcode == OP_JAL || i_opcode == OP_JALR)
      single_res = i_pc + 32'd4;
    else
      single_res = alu_res;
  end

`ifdef RV32M_DIV_EN
  logic        div_signed, a_neg, b_neg, div_quick, neg_q, neg_r, want_rem;
  logic [31:0] mag_a, mag_b, quick_res, rem, den, rem_next, quo_next, div_res;
  logic [32:0] trial;

  // Divide magnitudes; zero divisor and signed overflow bypass the iteration.
  always_comb begin
    div_signed = !i_func3[0];
    a_neg      = div_signed && op_a[31];
    b_neg      = div_signed && op_b[31];
    mag_a      = a_neg ? -op_a : op_a;
    mag_b      = b_neg ? -op_b : op_b;
    div_quick  = 1'b0;
    quick_res  = 32'd0;
    if (op_b == 32'd0) begin
      div_quick = 1'b1;
      quick_res = i_func3[1] ? op_a : 32'hFFFF_FFFF;
    end else if (div_signed && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
      div_quick = 1'b1;
      quick_res = i_func3[1] ? 32'd0 : 32'h8000_0000;
    end
    trial = {rem, work[31]} - {1'b0, den};
    if (!trial[32]) begin
      rem_next = trial[31:0];
      quo_next = {work[30:0], 1'b1};
    end else begin
      rem_next = {rem[30:0], work[31]};
      quo_next = {work[30:0], 1'b0};
    end
    if (want_rem)
      div_res = neg_r ? -rem_next : rem_next;
    else
      div_res = neg_q ? -quo_next : quo_next;
  end
`else
  logic unused_div;
  assign unused_div = i_div;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef RV32M_DIV_EN
          if (i_div) begin
            if (!div_quick) next_state = DIV;
          end else
`endif
          if (serial_go) next_state = SHIFT;
        end
      end
      default: if (last_step && !i_stall) next_state = IDLE;
    endcase
  end

  // The final multi-cycle step waits at count==1 until MEM releases the stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_ce       <= 1'b0;
      o_result   <= 32'd0;
      o_rs2_data <= 32'd0;
      o_pc       <= 32'd0;
      o_opcode   <= 7'd0;
      o_func3    <= 3'd0;
      work       <= 32'd0;
      count      <= 6'd0;
      sh_left    <= 1'b0;
      sh_arith   <= 1'b0;
`ifdef RV32M_DIV_EN
      rem        <= 32'd0;
      den        <= 32'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      want_rem   <= 1'b0;
`endif
    end else begin
      o_ce <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o_opcode   <= i_opcode;
            o_func3    <= i_func3;
            o_pc       <= i_pc;
            o_rs2_data <= i_rs2_data;
`ifdef RV32M_DIV_EN
            if (i_div) begin
              if (div_quick) begin
                o_result <= quick_res;
                o_ce     <= 1'b1;
              end else begin
                work     <= mag_a;
                rem      <= 32'd0;
                den      <= mag_b;
                count    <= 6'd32;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                want_rem <= i_func3[1];
              end
            end else
`endif
            if (serial_go) begin
              work     <= op_a;
              count    <= {1'b0, shamt};
              sh_left  <= (alu_op == 4'b0001);
              sh_arith <= (alu_op == 4'b1101);
            end else begin
              o_result <= single_res;
              o_ce     <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!last_step) begin
            work  <= shift_step;
            count <= count - 6'd1;
          end else if (!i_stall) begin
            o_result <= shift_step;
            o_ce     <= 1'b1;
            count    <= 6'd0;
          end
        end
`ifdef RV32M_DIV_EN
        DIV: begin
          if (!last_step) begin
            work  <= quo_next;
            rem   <= rem_next;
            count <= count - 6'd1;
          end else if (!i_stall) begin
            o_result <= div_res;
            o_ce     <= 1'b1;
            count    <= 6'd0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; DIV vectors run when RV32M_DIV_EN is defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm_data, i_pc;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func3;
  logic [3:0]  i_alu_ctrl;
  logic        i_ce, i_div, i_stall;
  logic        o_stall, o_ce;
  logic [31:0] o_result, o_rs2_data, o_pc;
  logic [6:0]  o_opcode;
  logic [2:0]  o_func3;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm_data(i_imm_data),
    .i_opcode(i_opcode), .i_func3(i_func3), .i_alu_ctrl(i_alu_ctrl), .i_pc(i_pc),
    .i_ce(i_ce), .i_div(i_div), .i_stall(i_stall),
    .o_stall(o_stall), .o_result(o_result), .o_rs2_data(o_rs2_data),
    .o_opcode(o_opcode), .o_func3(o_func3), .o_pc(o_pc), .o_ce(o_ce)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [3:0] alu,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic div);
    i_opcode   = opc;
    i_func3    = f3;
    i_alu_ctrl = alu;
    i_rs1_data = rs1;
    i_rs2_data = rs2;
    i_imm_data = imm;
    i_pc       = pc;
    i_div      = div;
    i_ce       = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; i_ce = 1'b0; i_div = 1'b0; i_stall = 1'b0;
    i_rs1_data = '0; i_rs2_data = '0; i_imm_data = '0; i_pc = '0;
    i_opcode = '0; i_func3 = '0; i_alu_ctrl = '0;
    tick(); tick();
    check_output("reset_ce", o_ce, 0);
    check_output("reset_result", o_result, 0);
    check_output("reset_stall", o_stall, 0);
    check_output("reset_pc", o_pc, 0);
    rst_n = 1'b1;

    // ADD immediate with negative imm
    apply_stimulus(7'b0010011, 3'b000, 4'b0000, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h40, 1'b0);
    tick();
    check_output("add_result", o_result, 32'd2);
    check_output("add_ce", o_ce, 1);
    check_output("add_stall", o_stall, 0);
    check_output("add_pc", o_pc, 32'h40);
    i_ce = 1'b0;
    tick();
    check_output("add_ce_drop", o_ce, 0);

    // Serial SRA by 4 with i_ce pulses while busy
    apply_stimulus(7'b0110011, 3'b101, 4'b1101, 32'h8000_0000, 32'd4, 32'd0, 32'h80, 1'b0);
    tick();
    check_output("sra_busy0", o_stall, 1);
    check_output("sra_ce0", o_ce, 0);
    apply_stimulus(7'b0010011, 3'b000, 4'b0000, 32'h55, 32'd0, 32'd1, 32'h999, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_output("sra_busy", o_stall, 1);
      check_output("sra_ce_busy", o_ce, 0);
    end
    i_ce = 1'b0;
    tick();
    check_output("sra_result", o_result, 32'hF800_0000);
    check_output("sra_ce", o_ce, 1);
    check_output("sra_stall_done", o_stall, 0);
    check_output("sra_pc", o_pc, 32'h80);
    check_output("sra_rs2", o_rs2_data, 32'd4);
    tick();
    check_output("sra_ce_once", o_ce, 0);
    check_output("sra_ignored_junk", o_pc, 32'h80);

    // Link and upper-immediate overrides
    apply_stimulus(7'b1101111, 3'b000, 4'b0000, 32'h7, 32'd0, 32'h20, 32'h100, 1'b0);
    tick();
    check_output("jal_result", o_result, 32'h104);
    apply_stimulus(7'b0010111, 3'b000, 4'b0000, 32'h7, 32'd0, 32'h1000, 32'h200, 1'b0);
    tick();
    check_output("auipc_result", o_result, 32'h1200);
    apply_stimulus(7'b0110111, 3'b000, 4'b0000, 32'h7, 32'd0, 32'hABCD_E000, 32'h204, 1'b0);
    tick();
    check_output("lui_result", o_result, 32'hABCD_E000);

    // SRL by 3 with MEM stall on the would-be completion edge
    apply_stimulus(7'b0010011, 3'b101, 4'b0101, 32'h1000_0000, 32'd0, 32'd3, 32'h300, 1'b0);
    tick();
    i_ce = 1'b0;
    check_output("srl_held_result", o_result, 32'hABCD_E000);
    check_output("srl_ce0", o_ce, 0);
    tick(); tick();
    i_stall = 1'b1;
    tick();
    check_output("srl_stall_ce", o_ce, 0);
    check_output("srl_stall_out", o_stall, 1);
    check_output("srl_stall_hold", o_result, 32'hABCD_E000);
    tick();
    check_output("srl_stall_ce2", o_ce, 0);
    i_stall = 1'b0;
    #1;
    check_output("srl_still_busy", o_stall, 1);
    tick();
    check_output("srl_result", o_result, 32'h0200_0000);
    check_output("srl_ce", o_ce, 1);
    check_output("srl_opcode", o_opcode, 32'h13);

    // MEM stall while idle reaches ID directly
    i_stall = 1'b1;
    #1;
    check_output("idle_stall_pass", o_stall, 1);
    i_stall = 1'b0;
    tick();

    // Reset in the middle of a 20-bit SLL
    apply_stimulus(7'b0010011, 3'b001, 4'b0001, 32'd1, 32'd0, 32'd20, 32'h400, 1'b0);
    tick();
    i_ce = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check_output("rst_mid_ce", o_ce, 0);
    check_output("rst_mid_stall", o_stall, 0);
    check_output("rst_mid_result", o_result, 0);
    rst_n = 1'b1;
    apply_stimulus(7'b0010011, 3'b000, 4'b0000, 32'd1, 32'd0, 32'd1, 32'h500, 1'b0);
    tick();
    check_output("post_rst_add", o_result, 32'd2);
    check_output("post_rst_ce", o_ce, 1);

    // Assorted single-cycle ALU vectors and boundary cases
    apply_stimulus(7'b0110011, 3'b000, 4'b1000, 32'd3, 32'd5, 32'd100, 32'h0, 1'b0);
    tick();
    check_output("sub_wrap", o_result, 32'hFFFF_FFFE);
    apply_stimulus(7'b0110011, 3'b010, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0);
    tick();
    check_output("slt_signed", o_result, 32'd1);
    apply_stimulus(7'b0110011, 3'b011, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0);
    tick();
    check_output("sltu", o_result, 32'd0);
    apply_stimulus(7'b0000011, 3'b010, 4'b0010, 32'h100, 32'd0, 32'd8, 32'h0, 1'b0);
    tick();
    check_output("load_addr", o_result, 32'h108);
    apply_stimulus(7'b0100011, 3'b010, 4'b0010, 32'h200, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 1'b0);
    tick();
    check_output("store_addr", o_result, 32'h1FC);
    check_output("store_data", o_rs2_data, 32'hDEAD_BEEF);
    apply_stimulus(7'b0110011, 3'b111, 4'b1111, 32'h1234, 32'h5678, 32'd0, 32'h0, 1'b0);
    tick();
    check_output("unknown_ctrl", o_result, 32'd0);
    apply_stimulus(7'b0010011, 3'b001, 4'b0001, 32'h1234, 32'd0, 32'd0, 32'h0, 1'b0);
    tick();
    check_output("sll_zero_result", o_result, 32'h1234);
    check_output("sll_zero_ce", o_ce, 1);
    check_output("sll_zero_stall", o_stall, 0);
    i_ce = 1'b0;
    tick();

`ifdef RV32M_DIV_EN
    // Signed divide, 33-edge latency
    apply_stimulus(7'b0110011, 3'b100, 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h600, 1'b1);
    tick();
    i_ce = 1'b0; i_div = 1'b0;
    check_output("div_busy", o_stall, 1);
    for (int k = 0; k < 31; k++) tick();
    check_output("div_not_done", o_ce, 0);
    tick();
    check_output("div_result", o_result, 32'hFFFF_FFFD);
    check_output("div_ce", o_ce, 1);
    apply_stimulus(7'b0110011, 3'b110, 4'b0110, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h604, 1'b1);
    tick();
    i_ce = 1'b0; i_div = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    check_output("rem_result", o_result, 32'hFFFF_FFFF);
    apply_stimulus(7'b0110011, 3'b101, 4'b0101, 32'd10, 32'd0, 32'd0, 32'h608, 1'b1);
    tick();
    check_output("divu_zero", o_result, 32'hFFFF_FFFF);
    check_output("divu_zero_ce", o_ce, 1);
    apply_stimulus(7'b0110011, 3'b100, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h60C, 1'b1);
    tick();
    check_output("div_ovf", o_result, 32'h8000_0000);
    i_ce = 1'b0; i_div = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
